// File: rtl/hms_clock_display.sv
// HH:MM:SS wall clock with run/set modes, 12/24 h display and field blinking.
// Time is kept in BCD in 24 h form; the display path converts to 12 h on the
// fly and drives six registered 7-segment digits {H10,H1,M10,M1,S10,S1}.
//
// Handshake: mode_btn and inc_btn are single-cycle pulses sampled on every
// rising clk edge; there is no ready/back-pressure, a pulse is consumed in the
// cycle it is seen. mode_btn takes priority and drops a coincident inc_btn.
module hms_clock_display #(
    parameter int CLK_HZ     = 50_000_000,
    parameter bit SEG_ACT_LO = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_btn,
    input  logic        inc_btn,
    input  logic        disp_12h,
    output logic [41:0] seg,
    output logic [23:0] time_bcd,
    output logic        pm,
    output logic        sec_tick,
    output logic        set_active
);

    localparam int             PW     = $clog2(CLK_HZ);
    localparam logic [PW-1:0]  P_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0]  P_HALF = PW'(CLK_HZ / 2);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [3:0]    h10_q, h1_q, m10_q, m1_q, s10_q, s1_q;
    logic [3:0]    h10_d, h1_d, m10_d, m1_d, s10_d, s1_d;
    logic          s_cy, m_cy;
    logic          tick, run_tick, inc_ok;
    logic [41:0]   seg_d;
    logic [4:0]    hr_bin, hr12;
    logic [3:0]    dh10, dh1;
    logic          h10_blank, blink_off;

    // 7-segment code for one digit, a..g on bits 6..0, polarity applied last
    function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank);
        logic [6:0] lo;
        case (d)
            4'd0:    lo = 7'b0000001;
            4'd1:    lo = 7'b1001111;
            4'd2:    lo = 7'b0010010;
            4'd3:    lo = 7'b0000110;
            4'd4:    lo = 7'b1001100;
            4'd5:    lo = 7'b0100100;
            4'd6:    lo = 7'b0100000;
            4'd7:    lo = 7'b0001111;
            4'd8:    lo = 7'b0000000;
            4'd9:    lo = 7'b0000100;
            default: lo = 7'b1111111;
        endcase
        if (blank) lo = 7'b1111111;
        return SEG_ACT_LO ? lo : ~lo;
    endfunction

    // BCD 00..59 increment; returns {carry_out, tens, units}
    function automatic logic [8:0] bcd60_inc(input logic [3:0] t, input logic [3:0] u);
        if (u != 4'd9)      return {1'b0, t, u + 4'd1};
        else if (t != 4'd5) return {1'b0, t + 4'd1, 4'd0};
        else                return {1'b1, 4'd0, 4'd0};
    endfunction

    // BCD 00..23 increment with wrap; returns {tens, units}
    function automatic logic [7:0] hour_inc(input logic [3:0] t, input logic [3:0] u);
        if (t == 4'd2 && u == 4'd3) return 8'h00;
        else if (u == 4'd9)         return {t + 4'd1, 4'd0};
        else                        return {t, u + 4'd1};
    endfunction

    assign tick       = (presc_q == P_MAX);
    assign run_tick   = tick && (state_q == RUN);
    assign inc_ok     = inc_btn && !mode_btn;
    assign set_active = (state_q != RUN);
    assign pm         = (h10_q == 4'd2) || (h10_q == 4'd1 && h1_q >= 4'd2);
    assign time_bcd   = {h10_q, h1_q, m10_q, m1_q, s10_q, s1_q};

    // Mode FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Mode FSM next state: one step per mode_btn pulse
    always_comb begin
        state_d = state_q;
        if (mode_btn) begin
            case (state_q)
                RUN:     state_d = SET_H;
                SET_H:   state_d = SET_M;
                SET_M:   state_d = SET_S;
                SET_S:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Prescaler: free-running divider, restarted on the return to RUN
    always_ff @(posedge clk) begin
        if (!reset)                                   presc_q <= '0;
        else if (tick || (mode_btn && state_q == SET_S)) presc_q <= '0;
        else                                          presc_q <= presc_q + 1'b1;
    end

    // Time next-state: carried seconds in RUN, per-field edits in set modes
    always_comb begin
        h10_d = h10_q; h1_d = h1_q;
        m10_d = m10_q; m1_d = m1_q;
        s10_d = s10_q; s1_d = s1_q;
        s_cy  = 1'b0;  m_cy = 1'b0;
        if (run_tick) begin
            {s_cy, s10_d, s1_d} = bcd60_inc(s10_q, s1_q);
            if (s_cy) begin
                {m_cy, m10_d, m1_d} = bcd60_inc(m10_q, m1_q);
                if (m_cy) {h10_d, h1_d} = hour_inc(h10_q, h1_q);
            end
        end else if (inc_ok) begin
            case (state_q)
                SET_H:   {h10_d, h1_d} = hour_inc(h10_q, h1_q);
                SET_M:   {m_cy, m10_d, m1_d} = bcd60_inc(m10_q, m1_q);
                SET_S:   begin s10_d = 4'd0; s1_d = 4'd0; end
                default: ;
            endcase
        end
    end

    // Time registers and the registered seconds strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            h10_q <= '0; h1_q <= '0; m10_q <= '0; m1_q <= '0; s10_q <= '0; s1_q <= '0;
            sec_tick <= 1'b0;
        end else begin
            h10_q <= h10_d; h1_q <= h1_d; m10_q <= m10_d;
            m1_q  <= m1_d;  s10_q <= s10_d; s1_q <= s1_d;
            sec_tick <= run_tick;
        end
    end

    // Display decode: 12 h conversion, blinking of the edited field
    always_comb begin
        hr_bin    = 5'(h10_q) * 5'd10 + 5'(h1_q);
        hr12      = hr_bin;
        dh10      = h10_q;
        dh1       = h1_q;
        h10_blank = 1'b0;
        if (hr_bin == 5'd0)      hr12 = 5'd12;
        else if (hr_bin > 5'd12) hr12 = hr_bin - 5'd12;
        if (disp_12h) begin
            if (hr12 >= 5'd10) begin
                dh10 = 4'd1;
                dh1  = 4'(hr12 - 5'd10);
            end else begin
                dh10 = 4'd0;
                dh1  = 4'(hr12);
            end
            h10_blank = (dh10 == 4'd0);
        end
        blink_off = (state_q != RUN) && (presc_q >= P_HALF);
        seg_d = {seg7(dh10,  h10_blank || (blink_off && state_q == SET_H)),
                 seg7(dh1,   blink_off && state_q == SET_H),
                 seg7(m10_q, blink_off && state_q == SET_M),
                 seg7(m1_q,  blink_off && state_q == SET_M),
                 seg7(s10_q, blink_off && state_q == SET_S),
                 seg7(s1_q,  blink_off && state_q == SET_S)};
    end

    // Segment register: shows 00:00:00 straight out of reset
    always_ff @(posedge clk) begin
        if (!reset) seg <= {6{seg7(4'd0, 1'b0)}};
        else        seg <= seg_d;
    end

endmodule

// File: tb/tb_hms_clock_display.sv
// Bench for hms_clock_display at CLK_HZ=10: vector table, hand sequences for
// the multi-cycle corners, then random buttons against a seconds-of-day model.
module tb_hms_clock_display;

  localparam int CLK_HZ = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mode_btn = 1'b0;
  logic        inc_btn = 1'b0;
  logic        disp_12h = 1'b0;
  logic [41:0] seg;
  logic [23:0] time_bcd;
  logic        pm;
  logic        sec_tick;
  logic        set_active;

  hms_clock_display #(.CLK_HZ(CLK_HZ), .SEG_ACT_LO(1'b1)) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .disp_12h(disp_12h), .seg(seg), .time_bcd(time_bcd), .pm(pm),
    .sec_tick(sec_tick), .set_active(set_active)
  );

  // clock
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  // reference model: time as seconds of day, mode 0=RUN 1=H 2=M 3=S
  int          m_secs  = 0;
  int          m_presc = 0;
  int          m_mode  = 0;
  logic        m_tick  = 1'b0;
  logic [41:0] m_seg   = '0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic        mb;
    logic        ib;
    logic [23:0] exp_time;
    logic        exp_sa;
  } vec_t;
  vec_t vecs[10];

  function automatic logic [6:0] code7(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [23:0] model_bcd(input int secs);
    int h, m, s;
    h = secs / 3600; m = (secs / 60) % 60; s = secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [41:0] model_seg(input int secs, input int presc, input int mode, input logic d12);
    int h, m, s, hd;
    logic blink;
    logic [6:0] c_h10, c_h1, c_m10, c_m1, c_s10, c_s1;
    h = secs / 3600; m = (secs / 60) % 60; s = secs % 60;
    hd = h;
    if (d12) hd = (h % 12 == 0) ? 12 : h % 12;
    c_h10 = code7(hd / 10); c_h1 = code7(hd % 10);
    if (d12 && hd < 10) c_h10 = 7'b1111111;
    c_m10 = code7(m / 10); c_m1 = code7(m % 10);
    c_s10 = code7(s / 10); c_s1 = code7(s % 10);
    blink = (mode != 0) && (presc >= CLK_HZ / 2);
    if (blink && mode == 1) begin c_h10 = 7'b1111111; c_h1 = 7'b1111111; end
    if (blink && mode == 2) begin c_m10 = 7'b1111111; c_m1 = 7'b1111111; end
    if (blink && mode == 3) begin c_s10 = 7'b1111111; c_s1 = 7'b1111111; end
    return {c_h10, c_h1, c_m10, c_m1, c_s10, c_s1};
  endfunction

  // advance the model across one clock edge
  task automatic model_edge(input logic rst_n, input logic mb, input logic ib, input logic d12);
    int h, m, s;
    logic tk;
    if (!rst_n) begin
      m_secs = 0; m_presc = 0; m_mode = 0; m_tick = 1'b0;
      m_seg = {6{code7(0)}};
    end else begin
      m_seg  = model_seg(m_secs, m_presc, m_mode, d12);
      tk     = (m_presc == CLK_HZ - 1);
      m_tick = tk && (m_mode == 0);
      if (m_tick) m_secs = (m_secs + 1) % 86400;
      m_presc = (mb && m_mode == 3) ? 0 : (m_presc + 1) % CLK_HZ;
      if (mb) begin
        m_mode = (m_mode + 1) % 4;
      end else if (ib) begin
        h = m_secs / 3600; m = (m_secs / 60) % 60; s = m_secs % 60;
        if (m_mode == 1) h = (h + 1) % 24;
        if (m_mode == 2) m = (m + 1) % 60;
        if (m_mode == 3) s = 0;
        m_secs = h * 3600 + m * 60 + s;
      end
    end
  endtask

  task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_model();
    chk("time_bcd",   42'(time_bcd),   42'(model_bcd(m_secs)));
    chk("pm",         42'(pm),         42'(m_secs >= 43200));
    chk("sec_tick",   42'(sec_tick),   42'(m_tick));
    chk("set_active", 42'(set_active), 42'(m_mode != 0));
    chk("seg",        seg,             m_seg);
  endtask

  // driver: apply one cycle of inputs, then compare against the model
  task automatic step(input logic mb, input logic ib, input logic rst_n);
    mode_btn = mb; inc_btn = ib; reset = rst_n;
    @(posedge clk);
    model_edge(rst_n, mb, ib, disp_12h);
    #1;
    if (!rst_n) cyc = 0;
    else        cyc++;
    check_model();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    logic found;
    logic rb_mb, rb_ib, rb_rst;

    vecs[0] = '{1'b1, 1'b0, 24'h000000, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 24'h010000, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 24'h020000, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 24'h020000, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 24'h020100, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 24'h020200, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 24'h020200, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 24'h020200, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 24'h020200, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 24'h020200, 1'b0};

    // reset state
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_time", 42'(time_bcd), 42'h0);
    chk("reset_seg",  seg, {6{7'b0000001}});
    chk("reset_sa",   42'(set_active), 42'h0);

    // seconds cadence: ticks exactly every CLK_HZ cycles
    exp_q.push_back(32'd10); exp_q.push_back(32'd20); exp_q.push_back(32'd30);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (sec_tick) begin
        if (exp_q.size() > 0) chk("tick_cycle", 42'(cyc), 42'(exp_q.pop_front()));
        else                  chk("tick_extra", 42'(cyc), 42'h0);
      end
    end
    chk("tick_missing", 42'(exp_q.size()), 42'h0);
    chk("run30_time", 42'(time_bcd), 42'h000003);

    // vector table from a fresh reset
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].mb, vecs[i].ib, 1'b1);
      chk($sformatf("vec%0d_time", i), 42'(time_bcd), 42'(vecs[i].exp_time));
      chk($sformatf("vec%0d_sa", i),   42'(set_active), 42'(vecs[i].exp_sa));
    end

    // tick coinciding with mode_btn in RUN: tick applied, then SET_H
    step(1'b0, 1'b0, 1'b0);
    run_cycles(9);
    step(1'b1, 1'b0, 1'b1);
    chk("tickmode_time", 42'(time_bcd), 42'h000001);
    chk("tickmode_tick", 42'(sec_tick), 42'h1);
    chk("tickmode_sa",   42'(set_active), 42'h1);

    // preload 23:59:00, run to 23:59:59 and roll over to midnight
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1); incs(23);
    step(1'b1, 1'b0, 1'b1); incs(59);
    step(1'b1, 1'b0, 1'b1); incs(1);
    step(1'b1, 1'b0, 1'b1);
    run_cycles(590);
    chk("pre_roll_time", 42'(time_bcd), 42'h235959);
    chk("pre_roll_pm",   42'(pm), 42'h1);
    run_cycles(10);
    chk("roll_time", 42'(time_bcd), 42'h000000);
    chk("roll_pm",   42'(pm), 42'h0);

    // SET_H wraps mod 24 and discards ticks
    step(1'b0, 1'b0, 1'b0);
    run_cycles(25);
    step(1'b1, 1'b0, 1'b1);
    incs(25);
    chk("seth_time", 42'(time_bcd), 42'h010002);
    chk("seth_sa",   42'(set_active), 42'h1);

    // SET_M wraps without carry; mode_btn beats inc_btn
    step(1'b1, 1'b0, 1'b1);
    incs(59);
    chk("setm_59", 42'(time_bcd), 42'h015902);
    incs(1);
    chk("setm_wrap", 42'(time_bcd), 42'h010002);
    step(1'b1, 1'b1, 1'b1);
    chk("mode_wins_time", 42'(time_bcd), 42'h010002);
    chk("mode_wins_sa",   42'(set_active), 42'h1);
    step(1'b1, 1'b0, 1'b1);

    // 12 h display: midnight hour shows 12, 13 h shows 1
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1);
    incs(5);
    step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1);
    disp_12h = 1'b1;
    run_cycles(2);
    chk("d12_midnight_h10", 42'(seg[41:35]), 42'(7'b1001111));
    chk("d12_midnight_h1",  42'(seg[34:28]), 42'(7'b0010010));
    step(1'b1, 1'b0, 1'b1); incs(13);
    step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b0, 1'b1);
    run_cycles(2);
    chk("d12_13h_h10", 42'(seg[41:35]), 42'(7'b1111111));
    chk("d12_13h_h1",  42'(seg[34:28]), 42'(7'b1001111));
    chk("d12_13h_pm",  42'(pm), 42'h1);
    disp_12h = 1'b0;

    // reset while SET_M is blinking
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1); step(1'b1, 1'b1, 1'b1);
    incs(3);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (seg[27:14] == 14'h3FFF) found = 1'b1;
    end
    chk("blink_seen", 42'(found), 42'h1);
    step(1'b0, 1'b1, 1'b0);
    chk("rst_mid_sa",   42'(set_active), 42'h0);
    chk("rst_mid_time", 42'(time_bcd), 42'h0);
    chk("rst_mid_seg",  seg, {6{7'b0000001}});

    // random buttons against the model
    for (int i = 0; i < 3000; i++) begin
      rb_rst = ($urandom_range(0, 299) != 0);
      rb_mb  = ($urandom_range(0, 9) == 0);
      rb_ib  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) disp_12h = ~disp_12h;
      step(rb_mb, rb_ib, rb_rst);
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
